// File: rtl/ysyx_22040750_rr_arbiter_pkg.sv
// Shared types and defaults for the round-robin arbiter and its winner picker.
package ysyx_22040750_rr_arbiter_pkg;

  localparam int unsigned DefaultM = 4;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

endpackage

// File: rtl/ysyx_22040750_rr_pick.sv
// Combinational rotating-priority winner search. I_ptr has the highest priority,
// and priority then wraps from M-1 back to 0.
module ysyx_22040750_rr_pick
  import ysyx_22040750_rr_arbiter_pkg::*;
#(
  parameter int unsigned M     = DefaultM,
  parameter int unsigned IDX_W = $clog2(M)
) (
  input  logic [M-1:0]     I_req,
  input  logic [IDX_W-1:0] I_ptr,
  output logic [M-1:0]     O_grant,
  output logic [IDX_W-1:0] O_idx,
  output logic             O_valid
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Visit the requesters in rotated order; the first one that is requesting wins.
  always_comb begin
    found   = 1'b0;
    cand    = '0;
    O_grant = '0;
    O_idx   = '0;
    for (int unsigned k = 0; k < M; k++) begin
      cand = IDX_W'((k + 32'(I_ptr)) % M);
      if (!found && I_req[cand]) begin
        found         = 1'b1;
        O_grant[cand] = 1'b1;
        O_idx         = cand;
      end
    end
  end

  assign O_valid = found;

endmodule

// File: rtl/ysyx_22040750_rr_arbiter.sv
// Round-robin arbiter that drives the one-hot select of the downstream mux.
// If YSYX_22040750_ARB_B2B_EN is defined, a new grant follows I_done with no idle cycle.
module ysyx_22040750_rr_arbiter
  import ysyx_22040750_rr_arbiter_pkg::*;
#(
  parameter int unsigned M     = DefaultM,
  parameter int unsigned IDX_W = $clog2(M)
) (
  input  logic             I_sys_clk,
  input  logic             I_rst_n,
  input  logic [M-1:0]     I_req,
  input  logic             I_done,
  output logic [M-1:0]     O_grant,
  output logic [IDX_W-1:0] O_grant_idx,
  output logic             O_busy
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [M-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [IDX_W-1:0] ptr_inc;
  logic [IDX_W-1:0] pick_ptr;
  logic [M-1:0]     pick_grant;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;

  // After a grant ends, priority moves to the requester just after the winner.
  assign ptr_inc = (idx_q == IDX_W'(M - 1)) ? '0 : idx_q + IDX_W'(1);

`ifdef YSYX_22040750_ARB_B2B_EN
  // When a back-to-back grant is made, the pick uses the pointer that I_done advances.
  assign pick_ptr = (state_q == StBusy) ? ptr_inc : ptr_q;
`else
  assign pick_ptr = ptr_q;
`endif

  ysyx_22040750_rr_pick #(
    .M    (M),
    .IDX_W(IDX_W)
  ) u_pick (
    .I_req  (I_req),
    .I_ptr  (pick_ptr),
    .O_grant(pick_grant),
    .O_idx  (pick_idx),
    .O_valid(pick_valid)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StBusy;
          grant_d = pick_grant;
          idx_d   = pick_idx;
        end
      end
      StBusy: begin
        if (I_done) begin
          ptr_d   = ptr_inc;
          state_d = StIdle;
          grant_d = '0;
          idx_d   = '0;
`ifdef YSYX_22040750_ARB_B2B_EN
          if (pick_valid) begin
            state_d = StBusy;
            grant_d = pick_grant;
            idx_d   = pick_idx;
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge I_sys_clk) begin
    if (!I_rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      grant_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
    end
  end

  assign O_grant     = grant_q;
  assign O_grant_idx = idx_q;
  assign O_busy      = (state_q == StBusy);

  a_grant_onehot0: assert property (@(posedge I_sys_clk) $onehot0(grant_q));

endmodule

// File: tb/tb_ysyx_22040750_rr_arbiter.sv
// Self-checking bench for ysyx_22040750_rr_arbiter: directed table, B2B sequence, random vs model.
module tb_ysyx_22040750_rr_arbiter;

  localparam int M = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // Reference state: is a grant held, who holds it, and who has top priority.
  bit m_busy;
  int m_idx;
  int m_ptr;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] idx;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  ysyx_22040750_rr_arbiter #(
    .M(M)
  ) dut (
    .I_sys_clk  (clk),
    .I_rst_n    (rst_n),
    .I_req      (req),
    .I_done     (done),
    .O_grant    (grant),
    .O_grant_idx(grant_idx),
    .O_busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Walk the requesters in priority order, starting at ptr.
  function automatic int choose(input logic [3:0] r, input int ptr);
    int order[$];
    for (int k = 0; k < M; k++) order.push_back((ptr + k) % M);
    foreach (order[n]) if (r[order[n]]) return order[n];
    return 0;
  endfunction

  task automatic model_tick(input logic r_n, input logic [3:0] r, input logic d);
    if (!r_n) begin
      m_busy = 0; m_idx = 0; m_ptr = 0;
    end else if (!m_busy) begin
      if (r != 4'b0) begin
        m_idx  = choose(r, m_ptr);
        m_busy = 1;
      end
    end else if (d) begin
      m_ptr  = (m_idx + 1) % M;
      m_busy = 0;
      m_idx  = 0;
`ifdef YSYX_22040750_ARB_B2B_EN
      if (r != 4'b0) begin
        m_idx  = choose(r, m_ptr);
        m_busy = 1;
      end
`endif
    end
  endtask

  task automatic check(input string name, input logic [3:0] eg, input logic [1:0] ei,
                       input logic eb);
    checks++;
    if (grant !== eg || grant_idx !== ei || busy !== eb) begin
      errors++;
      $display("FAIL %s: got grant=%b idx=%0d busy=%b, want grant=%b idx=%0d busy=%b",
               name, grant, grant_idx, busy, eg, ei, eb);
    end
  endtask

  // Drive one cycle of inputs, step the model, and sample 1 time unit after the edge.
  task automatic cycle(input logic r_n, input logic [3:0] r, input logic d);
    rst_n = r_n; req = r; done = d;
    model_tick(r_n, r, d);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string name);
    logic [3:0] eg;
    eg = m_busy ? 4'(1 << m_idx) : 4'b0;
    check(name, eg, 2'(m_idx), m_busy);
  endtask

  initial begin
    rst_n = 1'b0; req = 4'b0; done = 1'b0;
    m_busy = 0; m_idx = 0; m_ptr = 0;

    // The idle-release rows keep req at zero when done is high, so they hold in both builds.
    vecs.push_back('{1'b0, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0});  // reset wins over req
    vecs.push_back('{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0});
    vecs.push_back('{1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1});  // first grant
    vecs.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0});
    vecs.push_back('{1'b1, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1});  // rotation
    vecs.push_back('{1'b1, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1});
    vecs.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0});
    vecs.push_back('{1'b1, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1});
    for (int i = 0; i < 5; i++)                                    // hold against req change
      vecs.push_back('{1'b1, 4'b0001, 1'b0, 4'b0100, 2'd2, 1'b1});
    vecs.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0});
    vecs.push_back('{1'b1, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1});
    vecs.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0});  // ptr wraps to 0
    vecs.push_back('{1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1});
    vecs.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0});
    vecs.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0});  // done ignored when idle
    vecs.push_back('{1'b1, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1});
    vecs.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0});  // ptr 0
    vecs.push_back('{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1});
    vecs.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0});  // ptr 3
    vecs.push_back('{1'b1, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1});  // wrap/skip
    vecs.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0});  // ptr 2
    vecs.push_back('{1'b1, 4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1});
    vecs.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0});  // ptr 3
    vecs.push_back('{1'b1, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1});
    vecs.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0});  // reset mid-transaction
    vecs.push_back('{1'b1, 4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1});  // ptr back at 0
    vecs.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0});  // ptr 1

    foreach (vecs[i]) begin
      cycle(vecs[i].rst_n, vecs[i].req, vecs[i].done);
      check($sformatf("vec%0d", i), vecs[i].grant, vecs[i].idx, vecs[i].busy);
    end

    // Done while another requester waits: back-to-back grant, or an idle cycle first.
    cycle(1'b1, 4'b0001, 1'b0);
    check("b2b_first", 4'b0001, 2'd0, 1'b1);
    cycle(1'b1, 4'b0011, 1'b1);
`ifdef YSYX_22040750_ARB_B2B_EN
    check("b2b_next", 4'b0010, 2'd1, 1'b1);
`else
    check("bubble", 4'b0000, 2'd0, 1'b0);
    cycle(1'b1, 4'b0011, 1'b0);
    check("after_bubble", 4'b0010, 2'd1, 1'b1);
`endif
    cycle(1'b1, 4'b0000, 1'b1);
    check("b2b_release", 4'b0000, 2'd0, 1'b0);

    // Random traffic, checked against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic       r_n;
      logic [3:0] r;
      logic       d;
      r_n = ($urandom_range(0, 39) != 0);
      r   = 4'($urandom);
      d   = 1'($urandom);
      cycle(r_n, r, d);
      check_model($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
